// File: rtl/sys_pkg.sv
// Shared types and default sizing for the systolic-array feeder.
package sys_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultRow   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCompute,
    StDrain
  } sys_feeder_state_t;

endpackage

// File: rtl/sys_feeder_if.sv
// Weight and feature-vector stream handshakes between a source and the feeder.
interface sys_feeder_if
  import sys_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned ROW   = DefaultRow
);

  logic             w_valid;
  logic [WIDTH-1:0] w_data;
  logic             w_ready;
  logic             f_valid;
  logic [WIDTH-1:0] f_data [ROW];
  logic             f_ready;

  modport master (
    output w_valid, w_data, f_valid, f_data,
    input  w_ready, f_ready
  );

  modport slave (
    input  w_valid, w_data, f_valid, f_data,
    output w_ready, f_ready
  );

endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth data+valid shift register used to skew one feature row.
module skew_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // The head stage only captures on a transfer, so bubbles carry the previous word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(DEPTH); s++) begin
        data_q[s] <= '0;
      end
      valid_q <= '0;
    end else begin
      if (valid_i) begin
        data_q[0] <= data_i;
      end
      valid_q[0] <= valid_i;
      for (int s = 1; s < int'(DEPTH); s++) begin
        data_q[s]  <= data_q[s-1];
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  assign data_o  = data_q[DEPTH-1];
  assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/sys_feeder.sv
// Systolic-array feeder: preloads ROW weights, then streams skewed feature vectors.
// Define SYS_FEEDER_ZERO_PAD_EN to blank feature_out on rows whose in_en is low.
module sys_feeder
  import sys_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned ROW   = DefaultRow
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       k_len,
  sys_feeder_if.slave      bus,
  output logic             weight_en,
  output logic [WIDTH-1:0] weight_out,
  output logic             ctrl_out,
  output logic [ROW-1:0]   in_en,
  output logic [WIDTH-1:0] feature_out [ROW],
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(ROW + 1);

  sys_feeder_state_t state_q;
  logic [CW-1:0]     w_cnt_q;
  logic [CW-1:0]     drain_cnt_q;
  logic [7:0]        vec_cnt_q;
  logic [7:0]        k_len_q;
  logic              w_ready_q;
  logic              f_ready_q;
  logic              ctrl_q;
  logic              busy_q;
  logic              done_q;
  logic              weight_en_q;
  logic [WIDTH-1:0]  weight_q;

  logic w_fire;
  logic f_fire;

  assign w_fire = bus.w_valid & w_ready_q;
  assign f_fire = bus.f_valid & f_ready_q;

  // Outputs are registered alongside the state so they always reflect the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      w_cnt_q     <= '0;
      drain_cnt_q <= '0;
      vec_cnt_q   <= '0;
      k_len_q     <= '0;
      w_ready_q   <= 1'b0;
      f_ready_q   <= 1'b0;
      ctrl_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      weight_en_q <= 1'b0;
      weight_q    <= '0;
    end else begin
      done_q      <= 1'b0;
      weight_en_q <= w_fire;
      if (w_fire) begin
        weight_q <= bus.w_data;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StLoad;
            k_len_q   <= k_len;
            w_cnt_q   <= '0;
            w_ready_q <= 1'b1;
            ctrl_q    <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        StLoad: begin
          if (w_fire) begin
            if (w_cnt_q == CW'(ROW - 1)) begin
              w_cnt_q   <= '0;
              w_ready_q <= 1'b0;
              ctrl_q    <= 1'b0;
              if (k_len_q == 8'd0) begin
                state_q     <= StDrain;
                drain_cnt_q <= '0;
              end else begin
                state_q   <= StCompute;
                vec_cnt_q <= '0;
                f_ready_q <= 1'b1;
              end
            end else begin
              w_cnt_q <= w_cnt_q + CW'(1);
            end
          end
        end
        StCompute: begin
          if (f_fire) begin
            vec_cnt_q <= vec_cnt_q + 8'd1;
            if (vec_cnt_q + 8'd1 == k_len_q) begin
              state_q     <= StDrain;
              f_ready_q   <= 1'b0;
              drain_cnt_q <= '0;
            end
          end
        end
        StDrain: begin
          // Hold ROW cycles so the deepest row emits its last word before done.
          if (drain_cnt_q == CW'(ROW - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.w_ready = w_ready_q;
  assign bus.f_ready = f_ready_q;
  assign weight_en   = weight_en_q;
  assign weight_out  = weight_q;
  assign ctrl_out    = ctrl_q;
  assign busy        = busy_q;
  assign done        = done_q;

  for (genvar i = 0; i < int'(ROW); i++) begin : g_row
    logic             row_valid;
    logic [WIDTH-1:0] row_data;

    skew_delay_line #(
      .WIDTH(WIDTH),
      .DEPTH(i + 1)
    ) u_skew (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid_i(f_fire),
      .data_i (bus.f_data[i]),
      .valid_o(row_valid),
      .data_o (row_data)
    );

    assign in_en[i] = row_valid;
`ifdef SYS_FEEDER_ZERO_PAD_EN
    assign feature_out[i] = row_valid ? row_data : '0;
`else
    assign feature_out[i] = row_data;
`endif
  end

endmodule

// File: tb/tb_sys_feeder.sv
// Directed, table-driven bench for sys_feeder (WIDTH=8, ROW=4).
module tb_sys_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] k_len = 8'd0;
  logic       weight_en;
  logic [7:0] weight_out;
  logic       ctrl_out;
  logic [3:0] in_en;
  logic [7:0] feature_out [4];
  logic       busy;
  logic       done;

  sys_feeder_if #(.WIDTH(8), .ROW(4)) bus ();

  sys_feeder #(
    .WIDTH(8),
    .ROW  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .k_len      (k_len),
    .bus        (bus),
    .weight_en  (weight_en),
    .weight_out (weight_out),
    .ctrl_out   (ctrl_out),
    .in_en      (in_en),
    .feature_out(feature_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // One row = inputs applied before an edge and outputs expected just after it.
  typedef struct packed {
    logic        start;
    logic [7:0]  k_len;
    logic        w_valid;
    logic [7:0]  w_data;
    logic        f_valid;
    logic [31:0] f_data;
    logic [4:0]  flags;   // {busy, ctrl_out, w_ready, f_ready, weight_en}
    logic [7:0]  weight_out;
    logic [3:0]  in_en;
    logic [31:0] fo;      // compared only on rows whose in_en bit is expected high
    logic        done;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic st, input logic [7:0] kl, input logic wv, input logic [7:0] wd,
                     input logic fv, input logic [31:0] fd, input logic [4:0] fl,
                     input logic [7:0] wo, input logic [3:0] ie, input logic [31:0] fo,
                     input logic dn);
    vec_t v;
    v.start = st; v.k_len = kl; v.w_valid = wv; v.w_data = wd; v.f_valid = fv; v.f_data = fd;
    v.flags = fl; v.weight_out = wo; v.in_en = ie; v.fo = fo; v.done = dn;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic [7:0] kl, input logic wv, input logic [7:0] wd,
                       input logic fv, input logic [31:0] fd);
    start       = st;
    k_len       = kl;
    bus.w_valid = wv;
    bus.w_data  = wd;
    bus.f_valid = fv;
    for (int r = 0; r < 4; r++) bus.f_data[r] = fd[r*8 +: 8];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " w_ready"}, 32'(bus.w_ready), 32'd0);
    check({tag, " f_ready"}, 32'(bus.f_ready), 32'd0);
    check({tag, " ctrl_out"}, 32'(ctrl_out), 32'd0);
    check({tag, " weight_en"}, 32'(weight_en), 32'd0);
    check({tag, " weight_out"}, 32'(weight_out), 32'd0);
    check({tag, " in_en"}, 32'(in_en), 32'd0);
    check({tag, " feature_out"},
          {feature_out[3], feature_out[2], feature_out[1], feature_out[0]}, 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
  endtask

  task automatic run(input int first, input int last, input string tag);
    for (int i = first; i < last; i++) begin
      vec_t  v;
      string n;
      v = vecs[i];
      n = $sformatf("%s[%0d]", tag, i - first);
      drive(v.start, v.k_len, v.w_valid, v.w_data, v.f_valid, v.f_data);
      @(posedge clk);
      #1;
      check({n, " busy"}, 32'(busy), 32'(v.flags[4]));
      check({n, " ctrl_out"}, 32'(ctrl_out), 32'(v.flags[3]));
      check({n, " w_ready"}, 32'(bus.w_ready), 32'(v.flags[2]));
      check({n, " f_ready"}, 32'(bus.f_ready), 32'(v.flags[1]));
      check({n, " weight_en"}, 32'(weight_en), 32'(v.flags[0]));
      check({n, " weight_out"}, 32'(weight_out), 32'(v.weight_out));
      check({n, " in_en"}, 32'(in_en), 32'(v.in_en));
      check({n, " done"}, 32'(done), 32'(v.done));
      for (int r = 0; r < 4; r++) begin
        if (v.in_en[r]) begin
          check($sformatf("%s feature_out%0d", n, r), 32'(feature_out[r]),
                32'(v.fo[r*8 +: 8]));
        end
      end
    end
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0);
  endtask

  int a_lo, a_hi, b_lo, b_hi, c_lo, c_hi;

  initial begin
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0);

    // Job A: k_len=2, back-to-back weights, two vectors; start and w_valid noise while busy.
    a_lo = vecs.size();
    add(1, 2, 0, 0,  0, 0,            5'b11100, 0, 4'b0000, 0, 0);
    add(0, 0, 1, 1,  0, 0,            5'b11101, 1, 4'b0000, 0, 0);
    add(0, 0, 1, 2,  0, 0,            5'b11101, 2, 4'b0000, 0, 0);
    add(0, 0, 1, 3,  0, 0,            5'b11101, 3, 4'b0000, 0, 0);
    add(0, 0, 1, 4,  0, 0,            5'b10011, 4, 4'b0000, 0, 0);
    add(1, 7, 1, 99, 1, 32'h0d0c0b0a, 5'b10010, 4, 4'b0001, 32'h0000000a, 0);
    add(0, 0, 0, 0,  1, 32'h17161514, 5'b10000, 4, 4'b0011, 32'h00000b14, 0);
    add(1, 2, 0, 0,  0, 0,            5'b10000, 4, 4'b0110, 32'h000c1500, 0);
    add(0, 0, 0, 0,  0, 0,            5'b10000, 4, 4'b1100, 32'h0d160000, 0);
    add(0, 0, 0, 0,  0, 0,            5'b10000, 4, 4'b1000, 32'h17000000, 0);
    add(0, 0, 0, 0,  0, 0,            5'b00000, 4, 4'b0000, 0, 1);
    add(0, 0, 0, 0,  0, 0,            5'b00000, 4, 4'b0000, 0, 0);
    a_hi = vecs.size();

    // Job B: k_len=3 with a one-cycle f_valid bubble between the first two vectors.
    b_lo = vecs.size();
    add(1, 3, 0, 0, 0, 0,            5'b11100, 4, 4'b0000, 0, 0);
    add(0, 0, 1, 5, 0, 0,            5'b11101, 5, 4'b0000, 0, 0);
    add(0, 0, 1, 6, 0, 0,            5'b11101, 6, 4'b0000, 0, 0);
    add(0, 0, 1, 7, 0, 0,            5'b11101, 7, 4'b0000, 0, 0);
    add(0, 0, 1, 8, 0, 0,            5'b10011, 8, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 1, 32'h23222120, 5'b10010, 8, 4'b0001, 32'h00000020, 0);
    add(0, 0, 0, 0, 0, 0,            5'b10010, 8, 4'b0010, 32'h00002100, 0);
    add(0, 0, 0, 0, 1, 32'h33323130, 5'b10010, 8, 4'b0101, 32'h00220030, 0);
    add(0, 0, 0, 0, 1, 32'h43424140, 5'b10000, 8, 4'b1011, 32'h23003140, 0);
    add(0, 0, 0, 0, 0, 0,            5'b10000, 8, 4'b0110, 32'h00324100, 0);
    add(0, 0, 0, 0, 0, 0,            5'b10000, 8, 4'b1100, 32'h33420000, 0);
    add(0, 0, 0, 0, 0, 0,            5'b10000, 8, 4'b1000, 32'h43000000, 0);
    add(0, 0, 0, 0, 0, 0,            5'b00000, 8, 4'b0000, 0, 1);
    b_hi = vecs.size();

    // Job C: k_len=0 goes straight to DRAIN after the weights; f_valid there is ignored.
    c_lo = vecs.size();
    add(1, 0, 0, 0,  0, 0,            5'b11100, 8,  4'b0000, 0, 0);
    add(0, 0, 1, 9,  0, 0,            5'b11101, 9,  4'b0000, 0, 0);
    add(0, 0, 1, 10, 0, 0,            5'b11101, 10, 4'b0000, 0, 0);
    add(0, 0, 1, 11, 0, 0,            5'b11101, 11, 4'b0000, 0, 0);
    add(0, 0, 1, 12, 0, 0,            5'b10001, 12, 4'b0000, 0, 0);
    add(0, 0, 0, 0,  1, 32'h55555555, 5'b10000, 12, 4'b0000, 0, 0);
    add(0, 0, 0, 0,  0, 0,            5'b10000, 12, 4'b0000, 0, 0);
    add(0, 0, 0, 0,  0, 0,            5'b10000, 12, 4'b0000, 0, 0);
    add(0, 0, 0, 0,  0, 0,            5'b00000, 12, 4'b0000, 0, 1);
    add(0, 0, 0, 0,  0, 0,            5'b00000, 12, 4'b0000, 0, 0);
    c_hi = vecs.size();

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run(a_lo, a_hi, "jobA");
    run(b_lo, b_hi, "jobB");
    run(c_lo, c_hi, "jobC");

    // Reset during COMPUTE after one accepted vector.
    drive(1'b1, 8'd2, 1'b0, 8'd0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    for (int w = 1; w <= 4; w++) begin
      drive(1'b0, 8'd0, 1'b1, 8'(w), 1'b0, 32'd0);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 32'h0d0c0b0a);
    @(posedge clk);
    #1;
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0);
    check("rst_mid in_en", 32'(in_en), 32'h1);
    check("rst_mid f_ready", 32'(bus.f_ready), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_hold%0d done", c), 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(a_lo, a_hi, "jobA_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/sys_feeder.md
SYS_FEEDER -- requirements
Module: sys_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bit width of weight and feature words.
REQ-002 SHALL have parameter ROW, default 4, meaning number of PE rows fed, and the skew depth.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, meaning a one-cycle job request; honoured only in IDLE.
REQ-006 SHALL have port k_len, input, 8, meaning the number of feature vectors in the job; sampled on the accepted start.
REQ-007 SHALL have ports w_valid (input, 1), w_data (input, WIDTH) and w_ready (output, 1), meaning the weight stream handshake.
REQ-008 SHALL have ports f_valid (input, 1), f_data[ROW] (input, WIDTH each) and f_ready (output, 1), meaning the feature-vector stream handshake.
REQ-009 SHALL have ports weight_en (output, 1) and weight_out (output, WIDTH), meaning the weight chain head of the array.
REQ-010 SHALL have port ctrl_out, output, 1, meaning 1 = preload weights, 0 = compute.
REQ-011 SHALL have ports in_en[ROW] (output, 1 each) and feature_out[ROW] (output, WIDTH each), meaning the skewed per-row feature valids and data.
REQ-012 SHALL have ports busy (output, 1) and done (output, 1), meaning job active, and a one-cycle completion pulse.

Function
REQ-013 SHALL implement an FSM with states IDLE, LOAD, COMPUTE and DRAIN.
REQ-014 SHALL go IDLE->LOAD on start; start is ignored in any other state.
REQ-015 SHALL hold w_ready=1 in LOAD only; each w_valid&&w_ready transfer registers w_data to weight_out and asserts weight_en for exactly the next cycle.
REQ-016 SHALL go LOAD->COMPUTE after exactly ROW weight transfers, or LOAD->DRAIN if k_len==0; ctrl_out=1 throughout LOAD, 0 otherwise.
REQ-017 SHALL hold f_ready=1 in COMPUTE only; on each transfer f_data[i] enters row i's delay line, where row i is delayed i+1 cycles from acceptance in total.
REQ-018 SHALL drive in_en[i] as the accept strobe delayed by the same i+1 cycles; a cycle with no transfer propagates as a bubble (in_en[i]=0).
REQ-019 SHALL go COMPUTE->DRAIN in the cycle after the k_len-th transfer; the vector counter is 8-bit and does not wrap within a job.
REQ-020 SHALL stay in DRAIN exactly ROW cycles, so the last in_en[ROW-1] is emitted, then go DRAIN->IDLE with done=1 for one cycle.
REQ-021 SHALL drive busy=1 in all states except IDLE.
REQ-022 SHALL ignore w_valid outside LOAD and f_valid outside COMPUTE; no data is consumed.

Reset
REQ-023 SHALL, on rst_n low, immediately clear the state to IDLE, the counters to 0, all delay lines to 0, and all outputs to 0 (w_ready, f_ready, weight_en, weight_out, ctrl_out, in_en, feature_out, busy, done).
REQ-024 SHALL, on reset mid-job, abandon the job with no done pulse, and accept a new start on the first cycle after release.

Configuration
REQ-025 SHALL, with SYS_FEEDER_ZERO_PAD_EN defined, force feature_out[i]=0 in every cycle where in_en[i]=0.
REQ-026 SHALL, without SYS_FEEDER_ZERO_PAD_EN, drive feature_out[i] directly from the delay-line register, so stale data is visible under in_en[i]=0.

Structure
REQ-027 SHALL place the FSM state enum (sys_feeder_state_t) and default WIDTH/ROW constants in the shared package sys_pkg.
REQ-028 SHALL use one sub-module, skew_delay_line (parameters WIDTH and DEPTH; data plus valid shift register), instantiated once per row with DEPTH=i+1.

Verification
REQ-029 SHALL cover: ROW=4, start with k_len=2, weights 1,2,3,4 back-to-back -> weight_en high 4 consecutive cycles, weight_out=1,2,3,4, ctrl_out=1 for those cycles only.
REQ-030 SHALL cover: vectors {10,11,12,13} then {20,21,22,23} accepted on consecutive cycles -> feature_out[0]=10 one cycle after acceptance, feature_out[3]=13 four cycles after, in_en diagonal pattern, done 1 cycle after the final DRAIN cycle.
REQ-031 SHALL cover: f_valid low for one cycle between vectors -> a one-cycle in_en=0 bubble on every row, offset by row.
REQ-032 SHALL cover: k_len=0 -> LOAD, then DRAIN for 4 cycles, done=1, no in_en ever asserted.
REQ-033 SHALL cover: rst_n low during COMPUTE after 1 vector -> all outputs 0 immediately, no done, and a fresh job completes normally.
REQ-034 SHALL cover: start pulsed while busy, plus w_valid during COMPUTE -> both ignored, and the job result is unchanged.
